skeleton_dot_seq: RTL

- Next-generation math skeleton for on-device DUT testing over the UART register interface.
- Generalises the two-operand multiplier skeleton to a signed dot product of two SIZE_INPUT-element vectors, A·B.
- One shared multiplier, time-multiplexed by an FSM with an accumulator; the accumulated result is saturated to the system bus width.
- Operands, result and a saturation flag are readable through the same address space.

---
 rtl/skeleton_dot_seq.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/skeleton_dot_seq.sv
// -----------------------------------------------------------------------------
// skeleton_dot_seq
//
// Signed dot product A.B of two SIZE_INPUT-element operand vectors. The vectors
// are loaded and the result is read back through a small register map. A single
// shared multiplier is time-multiplexed by an FSM that feeds an accumulator. The
// accumulator is wide enough that it never wraps. The final sum is saturated to
// the bus width, and SAT records whether clipping happened.
//
// Ports
//   CLK_SYS          system clock, every register updates on its rising edge
//   nRST             synchronous active-low reset
//   EN               block enable; EN=0 clears the block exactly like reset
//   TRGG_START_CALC  start trigger; IDLE arms on high, the calculation starts
//                    on the first edge that samples it low again
//   RnW              1 = read, 0 = write
//   ADR              register address:
//                      0..N-1  A[i]
//                      N..2N-1 B[i]
//                      2N      result (read-only)
//                      others  write-ignored, read 0
//   DATA_IN          write data; the operand is DATA_IN[SYS-1 -: IN]
//   DATA_OUT         read data, combinational mux on ADR
//   DATA_HEAD        constant block metadata
//   RDY              block enabled, idle and trigger low
//   SAT              last result was saturated
//   state_dbg        current FSM state (0 IDLE, 1 ARMED, 2 CALC, 3 DONE)
//
// Handshake: the host may write while RDY/ARMED (state IDLE or ARMED). It
// raises TRGG_START_CALC for at least one edge, then drops it. The host must
// then wait for RDY=1 before reading the result. Writes and trigger pulses
// made while the calculation is running are dropped.
// -----------------------------------------------------------------------------
module skeleton_dot_seq #(
  parameter int BITWIDTH_IN   = 8,
  parameter int SIZE_INPUT    = 4,
  parameter int BITWIDTH_ADR  = 6,
  parameter int BITWIDTH_SYS  = 16,
  parameter int BITWIDTH_HEAD = 32
) (
  input  logic                      CLK_SYS,
  input  logic                      nRST,
  input  logic                      EN,
  input  logic                      TRGG_START_CALC,
  input  logic                      RnW,
  input  logic [BITWIDTH_ADR-1:0]   ADR,
  input  logic [BITWIDTH_SYS-1:0]   DATA_IN,
  output logic [BITWIDTH_SYS-1:0]   DATA_OUT,
  output logic [BITWIDTH_HEAD-7:0]  DATA_HEAD,
  output logic                      RDY,
  output logic                      SAT,
  output logic [1:0]                state_dbg
);

  localparam int N      = SIZE_INPUT;
  localparam int IDX_W  = $clog2(N);
  localparam int PROD_W = 2 * BITWIDTH_IN;
  // One growth bit per doubling of N keeps the sum of N full-scale products
  // from ever wrapping.
  localparam int ACC_W  = PROD_W + IDX_W;
  // Saturation compare runs at the wider of accumulator and bus width, so the
  // clip limits are always representable.
  localparam int CMP_W  = (ACC_W > BITWIDTH_SYS) ? ACC_W : BITWIDTH_SYS;

  localparam logic signed [CMP_W-1:0] SAT_MAX =
    {{(CMP_W-BITWIDTH_SYS+1){1'b0}}, {(BITWIDTH_SYS-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] SAT_MIN =
    {{(CMP_W-BITWIDTH_SYS+1){1'b1}}, {(BITWIDTH_SYS-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_CALC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                          state;
  logic signed [BITWIDTH_IN-1:0]   a_reg [N];
  logic signed [BITWIDTH_IN-1:0]   b_reg [N];
  logic        [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]         acc;
  logic signed [BITWIDTH_SYS-1:0]  result;
  logic                            sat_q;

  logic signed [BITWIDTH_IN-1:0]   a_sel;
  logic signed [BITWIDTH_IN-1:0]   b_sel;
  logic signed [PROD_W-1:0]        prod;
  logic signed [ACC_W-1:0]         prod_ext;
  logic signed [CMP_W-1:0]         acc_ext;
  logic        [BITWIDTH_IN-1:0]   wr_val;
  logic                            wr_ok;
  logic        [BITWIDTH_SYS-1:0]  data_in_unused;

  // Only the MSB-aligned slice carries the operand; the low bits are don't-care.
  assign wr_val         = DATA_IN[BITWIDTH_SYS-1 -: BITWIDTH_IN];
  assign data_in_unused = DATA_IN;
  assign wr_ok          = !RnW && (state == S_IDLE || state == S_ARMED);

  // Operand pair feeding the shared multiplier.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IDX_W'(i)) begin
        a_sel = a_reg[i];
        b_sel = b_reg[i];
      end
    end
  end

  assign prod     = a_sel * b_sel;
  assign prod_ext = {{IDX_W{prod[PROD_W-1]}}, prod};
  assign acc_ext  = CMP_W'(acc);

  always_ff @(posedge CLK_SYS) begin
    if (!nRST || !EN) begin
      state  <= S_IDLE;
      idx    <= '0;
      acc    <= '0;
      result <= '0;
      sat_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        a_reg[i] <= '0;
        b_reg[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        for (int i = 0; i < N; i++) begin
          if (ADR == BITWIDTH_ADR'(i))     a_reg[i] <= wr_val;
          if (ADR == BITWIDTH_ADR'(N + i)) b_reg[i] <= wr_val;
        end
      end
      case (state)
        S_IDLE: begin
          if (TRGG_START_CALC) state <= S_ARMED;
        end
        S_ARMED: begin
          // Start on the trigger's falling edge; a held trigger keeps us armed.
          if (!TRGG_START_CALC) begin
            state <= S_CALC;
            idx   <= '0;
            acc   <= '0;
          end
        end
        S_CALC: begin
          acc <= acc + prod_ext;
          idx <= idx + 1'b1;
          if (idx == IDX_W'(N - 1)) state <= S_DONE;
        end
        S_DONE: begin
          if (acc_ext > SAT_MAX) begin
            result <= SAT_MAX[BITWIDTH_SYS-1:0];
            sat_q  <= 1'b1;
          end else if (acc_ext < SAT_MIN) begin
            result <= SAT_MIN[BITWIDTH_SYS-1:0];
            sat_q  <= 1'b1;
          end else begin
            result <= acc_ext[BITWIDTH_SYS-1:0];
            sat_q  <= 1'b0;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read mux: operands come back MSB-aligned with zero LSBs.
  always_comb begin
    DATA_OUT = '0;
    for (int i = 0; i < N; i++) begin
      if (ADR == BITWIDTH_ADR'(i))
        DATA_OUT[BITWIDTH_SYS-1 -: BITWIDTH_IN] = a_reg[i];
      if (ADR == BITWIDTH_ADR'(N + i))
        DATA_OUT[BITWIDTH_SYS-1 -: BITWIDTH_IN] = b_reg[i];
    end
    if (ADR == BITWIDTH_ADR'(2 * N)) DATA_OUT = result;
  end

  assign DATA_HEAD = {4'd2, 1'b0, 5'(SIZE_INPUT), 6'd1, 5'(BITWIDTH_IN),
                      5'(BITWIDTH_SYS)};
  assign RDY       = EN && nRST && (state == S_IDLE) && !TRGG_START_CALC;
  assign SAT       = sat_q;
  assign state_dbg = state;

endmodule
